// File: rtl/microprocessor_pkg.sv
// Shared definitions for the 8-bit teaching microprocessor: field widths,
// opcode encoding and the seven-segment glyph table.
package microprocessor_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned PC_W      = 8;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned MEM_DEPTH = 32;
  localparam int unsigned NUM_REGS  = 4;
  localparam int unsigned FIELD_W   = 2;
  localparam int unsigned SEG_W     = 7;

  typedef enum logic [FIELD_W-1:0] {
    OP_ADD   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_JUMP  = 2'b11
  } opcode_e;

  // Active-high segments, bit0 = a ... bit6 = g.
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [SEG_W-1:0] seg_encode(input logic [3:0] digit);
    return SEG_TABLE[digit];
  endfunction

endpackage

// File: rtl/microprocessor_seven_seg_decoder.sv
// Hex nibble to seven-segment pattern, purely combinational.
module seven_seg_decoder
  import microprocessor_pkg::*;
(
  input  logic [3:0]       digit,
  output logic [SEG_W-1:0] segments
);

  always_comb segments = seg_encode(digit);

endmodule

// File: rtl/microprocessor.sv
// Single-cycle 8-bit microprocessor with a 4-entry register file, 32-byte
// data memory, a step clock divider and seven-segment debug displays.
module microprocessor
  import microprocessor_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic              origclk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instruction,
  output logic [PC_W-1:0]   pc,
  output logic [SEG_W-1:0]  display_low,
  output logic [SEG_W-1:0]  display_high,
  output logic [SEG_W-1:0]  display_op,
  output logic [SEG_W-1:0]  display_rs,
  output logic [SEG_W-1:0]  display_rt,
  output logic [SEG_W-1:0]  display_rd,
  output logic [4:0]        display_pc,
  output logic              display_clock
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] mem  [MEM_DEPTH];

  logic [DIV_W-1:0] div_cnt;
  logic             step;

  opcode_e            op;
  logic [FIELD_W-1:0] rs, rt, rd;
  logic [ADDR_W-1:0]  imm2_off;
  logic [PC_W-1:0]    imm6_ext;
  logic [DATA_W-1:0]  rs_val, rt_val, mem_rdata;
  logic [ADDR_W-1:0]  addr;
  logic [DATA_W-1:0]  result;
  logic [PC_W-1:0]    pc_next;
  logic               reg_we;
  logic [FIELD_W-1:0] reg_waddr;
  logic [DATA_W-1:0]  reg_wdata;
  logic               mem_we;

  logic [DATA_W-1:0]  disp_result;
  logic [FIELD_W-1:0] disp_op, disp_rs, disp_rt, disp_rd;

  always_comb step = (div_cnt == DIV_LAST);

  always_comb begin
    op        = opcode_e'(instruction[7:6]);
    rs        = instruction[5:4];
    rt        = instruction[3:2];
    rd        = instruction[1:0];
    imm2_off  = {{3{instruction[1]}}, instruction[1:0]};
    imm6_ext  = {{2{instruction[5]}}, instruction[5:0]};
    rs_val    = regs[rs];
    rt_val    = regs[rt];
    // Addresses wrap within 32 bytes, so only the low five bits are summed.
    addr      = rs_val[ADDR_W-1:0] + imm2_off;
    mem_rdata = mem[addr];

    result    = '0;
    pc_next   = pc + 8'd1;
    reg_we    = 1'b0;
    reg_waddr = rd;
    reg_wdata = '0;
    mem_we    = 1'b0;

    case (op)
      OP_ADD: begin
        reg_we    = 1'b1;
        reg_waddr = rd;
        reg_wdata = rs_val + rt_val;
        result    = rs_val + rt_val;
      end
      OP_LOAD: begin
        reg_we    = 1'b1;
        reg_waddr = rt;
        reg_wdata = mem_rdata;
        result    = mem_rdata;
      end
      OP_STORE: begin
        mem_we = 1'b1;
        result = rt_val;
      end
      OP_JUMP: begin
        pc_next = pc + 8'd1 + imm6_ext;
        result  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge origclk or negedge reset) begin
    if (!reset) begin
      div_cnt       <= '0;
      pc            <= '0;
      regs          <= '{default: '0};
      for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
        mem[i[ADDR_W-1:0]] <= {3'b000, i[ADDR_W-1:0]};
      end
      disp_result   <= '0;
      disp_op       <= '0;
      disp_rs       <= '0;
      disp_rt       <= '0;
      disp_rd       <= '0;
      display_pc    <= '0;
      display_clock <= 1'b0;
    end else begin
      div_cnt <= step ? '0 : div_cnt + 1'b1;
      if (step) begin
        pc <= pc_next;
        if (reg_we) regs[reg_waddr] <= reg_wdata;
        if (mem_we) mem[addr] <= rt_val;
        disp_result   <= result;
        disp_op       <= instruction[7:6];
        disp_rs       <= rs;
        disp_rt       <= rt;
        disp_rd       <= rd;
        display_pc    <= pc[4:0];
        display_clock <= ~display_clock;
      end
    end
  end

  seven_seg_decoder u_seg_low  (.digit(disp_result[3:0]),   .segments(display_low));
  seven_seg_decoder u_seg_high (.digit(disp_result[7:4]),   .segments(display_high));
  seven_seg_decoder u_seg_op   (.digit({2'b00, disp_op}),   .segments(display_op));
  seven_seg_decoder u_seg_rs   (.digit({2'b00, disp_rs}),   .segments(display_rs));
  seven_seg_decoder u_seg_rt   (.digit({2'b00, disp_rt}),   .segments(display_rt));
  seven_seg_decoder u_seg_rd   (.digit({2'b00, disp_rd}),   .segments(display_rd));

endmodule

// File: tb/tb_microprocessor.sv
// Directed self-checking bench: reset state, load/add/store program, jump,
// asynchronous mid-run reset, ADD overflow and divided step clock.
module tb_microprocessor;

  logic       origclk = 1'b0;
  logic       reset;
  logic       reset4;
  logic [7:0] instruction, pc;
  logic [6:0] display_low, display_high, display_op, display_rs, display_rt, display_rd;
  logic [4:0] display_pc;
  logic       display_clock;

  logic [7:0] instruction4, pc4;
  logic [6:0] low4, high4, op4, rs4, rt4, rd4;
  logic [4:0] dpc4;
  logic       dclk4;

  logic [7:0] imem [256];

  int checks = 0;
  int errors = 0;

  always #5 origclk = ~origclk;

  assign instruction  = imem[pc];
  assign instruction4 = 8'h00;

  microprocessor dut (
    .origclk(origclk), .reset(reset), .instruction(instruction), .pc(pc),
    .display_low(display_low), .display_high(display_high),
    .display_op(display_op), .display_rs(display_rs),
    .display_rt(display_rt), .display_rd(display_rd),
    .display_pc(display_pc), .display_clock(display_clock)
  );

  microprocessor #(.CLK_DIV(4)) dut4 (
    .origclk(origclk), .reset(reset4), .instruction(instruction4), .pc(pc4),
    .display_low(low4), .display_high(high4),
    .display_op(op4), .display_rs(rs4),
    .display_rt(rt4), .display_rd(rd4),
    .display_pc(dpc4), .display_clock(dclk4)
  );

  function automatic logic [7:0] seg(input logic [3:0] n);
    case (n)
      4'h0: return 8'h3F;  4'h1: return 8'h06;  4'h2: return 8'h5B;  4'h3: return 8'h4F;
      4'h4: return 8'h66;  4'h5: return 8'h6D;  4'h6: return 8'h7D;  4'h7: return 8'h07;
      4'h8: return 8'h7F;  4'h9: return 8'h6F;  4'hA: return 8'h77;  4'hB: return 8'h7C;
      4'hC: return 8'h39;  4'hD: return 8'h5E;  4'hE: return 8'h79;  default: return 8'h71;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge origclk);
    #1;
  endtask

  initial begin
    reset  = 1'b0;
    reset4 = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
    for (int k = 0; k < 5; k++) begin
      imem[4*k]     = 8'h44;
      imem[4*k + 1] = 8'h49;
      imem[4*k + 2] = 8'h19;
      imem[4*k + 3] = 8'h84;
    end
    imem[20] = 8'hC3;

    // Reset state, sampled while reset is still held
    repeat (2) @(posedge origclk);
    #2;
    check("rst_pc",       pc, 8'h00);
    check("rst_low",      {1'b0, display_low},  8'h3F);
    check("rst_high",     {1'b0, display_high}, 8'h3F);
    check("rst_op",       {1'b0, display_op},   8'h3F);
    check("rst_rs",       {1'b0, display_rs},   8'h3F);
    check("rst_rt",       {1'b0, display_rt},   8'h3F);
    check("rst_rd",       {1'b0, display_rd},   8'h3F);
    check("rst_dpc",      {3'b000, display_pc}, 8'h00);
    check("rst_dclk",     {7'b0, display_clock}, 8'h00);

    @(negedge origclk);
    reset = 1'b1;

    // Repeating load/load/add/store, each store shows running count
    for (int k = 0; k < 20; k++) begin
      tick();
      check("prog_pc", pc, 8'(k + 1));
      if (k % 4 == 3) begin
        check("store_low",  {1'b0, display_low},  seg(4'(k / 4 + 1)));
        check("store_high", {1'b0, display_high}, 8'h3F);
      end
    end
    check("mem0_after", dut.mem[0],  8'h05);
    check("r1_after",   dut.regs[1], 8'h05);
    check("r2_after",   dut.regs[2], 8'h01);

    // Jump C3 at pc 20 -> 24
    tick();
    check("jump_pc",   pc, 8'd24);
    check("jump_low",  {1'b0, display_low},  8'h3F);
    check("jump_high", {1'b0, display_high}, 8'h3F);
    check("jump_op",   {1'b0, display_op},   8'h4F);
    check("jump_rs",   {1'b0, display_rs},   8'h3F);
    check("jump_rd",   {1'b0, display_rd},   8'h4F);
    check("jump_dpc",  {3'b000, display_pc}, 8'd20);
    check("jump_dclk", {7'b0, display_clock}, 8'h01);

    // Asynchronous reset between edges
    #3;
    reset = 1'b0;
    #1;
    check("async_pc",   pc, 8'h00);
    check("async_mem0", dut.mem[0],  8'h00);
    check("async_mem31", dut.mem[31], 8'h1F);
    check("async_r1",   dut.regs[1], 8'h00);
    check("async_low",  {1'b0, display_low}, 8'h3F);
    check("async_op",   {1'b0, display_op},  8'h3F);
    check("async_dclk", {7'b0, display_clock}, 8'h00);

    // Build FF in R3, store it, reload R1=FF, R2=01, then overflow ADD
    imem[0]  = 8'h4F;
    imem[1]  = 8'h49;
    imem[2]  = 8'h3F;
    imem[3]  = 8'h3B;
    imem[4]  = 8'h3F;
    imem[5]  = 8'h3B;
    imem[6]  = 8'h3F;
    imem[7]  = 8'h3B;
    imem[8]  = 8'h8C;
    imem[9]  = 8'h44;
    imem[10] = 8'h49;
    imem[11] = 8'h19;
    @(negedge origclk);
    reset = 1'b1;

    tick();
    check("ld_wrap_low",  {1'b0, display_low},  8'h71);
    check("ld_wrap_high", {1'b0, display_high}, 8'h06);
    tick();
    check("ld_one_low",   {1'b0, display_low},  8'h06);
    repeat (6) tick();
    check("r3_ff",        dut.regs[3], 8'hFF);
    tick();
    check("st_ff_low",    {1'b0, display_low},  8'h71);
    check("st_ff_high",   {1'b0, display_high}, 8'h71);
    check("st_ff_mem0",   dut.mem[0], 8'hFF);
    repeat (2) tick();
    check("ovf_r1_pre",   dut.regs[1], 8'hFF);
    check("ovf_r2_pre",   dut.regs[2], 8'h01);
    tick();
    check("ovf_r1",       dut.regs[1], 8'h00);
    check("ovf_low",      {1'b0, display_low},  8'h3F);
    check("ovf_high",     {1'b0, display_high}, 8'h3F);
    check("ovf_pc",       pc, 8'd12);

    // Divided step clock: one step per four edges
    reset4 = 1'b1;
    for (int s = 1; s <= 3; s++) begin
      for (int e = 1; e <= 4; e++) begin
        tick();
        check("div_pc",   pc4, (e == 4) ? 8'(s) : 8'(s - 1));
        check("div_dclk", {7'b0, dclk4}, (e == 4) ? {7'b0, s[0]} : {7'b0, ~s[0]});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/microprocessor.md
MICROPROCESSOR -- requirements
Module: microprocessor

Interface
REQ-001 Parameter CLK_DIV, default 1: number of origclk rising edges per processor step (board builds override, e.g. 25_000_000).
REQ-002 origclk  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 instruction  input  8  instruction word currently addressed by pc, supplied combinationally by external instruction memory.
REQ-005 pc  output  8  program counter (instruction address).
REQ-006 display_low / display_high  output  7 each  seven-segment pattern of low / high hex nibble of the last step's result value.
REQ-007 display_op / display_rs / display_rt / display_rd  output  7 each  seven-segment digit (0-3) of the last executed instruction's op / rs / rt / rd fields.
REQ-008 display_pc  output  5  pc[4:0] of the last executed instruction, for LEDs.
REQ-009 display_clock  output  1  step indicator, toggles once per processor step.

Function
REQ-010 Format: op=[7:6], rs=[5:4], rt=[3:2], rd=[1:0]; imm2=[1:0] sign-extended to 8 bits; imm6=[5:0] sign-extended to 8 bits.
REQ-011 State: register file R0-R3 (8 bits each), data memory of 32 x 8 bits, pc (8 bits).
REQ-012 A step occurs on every CLK_DIV-th origclk rising edge (free-running divider counter, wraps to 0); each step executes exactly one instruction completely (single-cycle).
REQ-013 op=00 ADD: R[rd] <= R[rs] + R[rt], modulo 256, carry discarded; result = sum; pc <= pc+1.
REQ-014 op=01 LOAD: R[rt] <= MEM[(R[rs]+imm2)[4:0]]; result = loaded byte; pc <= pc+1.
REQ-015 op=10 STORE: MEM[(R[rs]+imm2)[4:0]] <= R[rt]; result = R[rt]; pc <= pc+1.
REQ-016 op=11 JUMP: pc <= pc+1+imm6, modulo 256; no register/memory change; result = 8'h00.
REQ-017 Register and memory reads use values before the step; a write to a register read by the same instruction becomes visible in the next step only.
REQ-018 pc wraps 8'hFF -> 8'h00; address computations use only bits [4:0] (wrap within 32 bytes).
REQ-019 At each step, display_* outputs register the executed instruction's fields, result and pc[4:0]; they hold between steps.
REQ-020 Segment encoding, active-high, bit0=a .. bit6=g: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F,A=77,b=7C,C=39,d=5E,E=79,F=71 (hex).

Reset
REQ-021 While reset=0, asynchronously: pc=0, R0-R3=0, MEM[i]=i for i=0..31, divider=0, display_clock=0, display_pc=0, all seven-segment outputs = 3F (digit 0).
REQ-022 The first step occurs CLK_DIV origclk rising edges after reset deasserts; reset asserted mid-operation aborts the step and restores REQ-021 state immediately.

Structure
REQ-023 Shared package microprocessor_pkg holds opcode constants (OP_ADD, OP_LOAD, OP_STORE, OP_JUMP), field widths and the segment table.
REQ-024 One sub-module seven_seg_decoder (4-bit in, 7-bit pattern out), instantiated six times; register file, memory, divider and control remain in the top module.

Verification
REQ-025 Reset pulse -> pc=0, all segment outputs 3F, display_pc=0, display_clock=0.
REQ-026 CLK_DIV=1, program repeating {44,49,19,84} five times at pc 0-19 -> each STORE shows result 01,02,03,04,05 in turn; after pc 19, MEM[0]=05, R1=05, R2=01.
REQ-027 After REQ-026, instruction C3 at pc 20 -> pc=24, result display 00, display_op=4F (3).
REQ-028 ADD overflow: R1=FF, R2=01 by loads, then 19 -> R1=00, display_high=3F, display_low=3F.
REQ-029 CLK_DIV=4 -> pc changes once every 4 origclk edges and display_clock toggles at each pc change.
REQ-030 Reset asserted between steps mid-program -> pc=0 and MEM[0]=00 immediately, without waiting for a clock edge.
